instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Program-counter and fetch unit that produces the 9-bit machine word consumed by the control decoder. It resolves the decoder's Branch/targetLUT outputs against the status (sc) flag using a 16-entry jump-target table, and drives the instruction ROM address. The unit also sequences program start and done, and counts executed cycles.

Parameters:
PC_W, 10, program counter and instruction address width
INSTR_W, 9, machine-word width
LUT_DEPTH, 16, jump-target table entries (index width = clog2(LUT_DEPTH) = 4)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high
start  in  1  begin execution at address 0 (sampled in IDLE/DONE only)
prog_last  in  PC_W  address of final instruction
rom_addr  out  PC_W  instruction ROM address (= PC)
rom_data  in  INSTR_W  combinational ROM read of rom_addr
instr  out  INSTR_W  word to decoder; rom_data when running, else 0 (no-op-safe)
instr_valid  out  1  high in RUN
branch  in  2  decoder Branch: 00 none, 01 taken if sc=1, 10 taken if sc=0, 11 always
target_sel  in  4  decoder targetLUT index
sc_in  in  1  current status flag
lut_wr_en  in  1  write jump-target table
lut_wr_idx  in  4  table write index
lut_wr_data  in  PC_W  table write value
done  out  1  level, high in DONE
cycle_cnt  out  16  cycles spent in RUN for the current/last program

Behaviour:
- Reset (async): state=IDLE, PC=0, all LUT entries=0, cycle_cnt=0, done=0, instr_valid=0, instr=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN next cycle with PC=0 and cycle_cnt=0.
  - RUN: each cycle one instruction; instr=rom_data combinationally (zero extra latency); branch decision applies to the next PC.
    - taken = (branch==11) | (branch==01 & sc_in) | (branch==10 & ~sc_in).
    - next PC = taken ? LUT[target_sel] : PC+1.
    - If not taken and PC==prog_last -> DONE; PC holds.
    - A taken branch at prog_last stays in RUN.
    - cycle_cnt increments every RUN cycle and saturates at 16'hFFFF.
  - DONE: done=1, PC holds, cycle_cnt holds. start=1 -> RUN from PC=0, cycle_cnt cleared.
- start in RUN is ignored.
- PC+1 wraps modulo 2^PC_W (1023 -> 0) with no error.
- LUT write is accepted in any state. If a write and a branch lookup hit the same index in the same cycle, the branch uses the old entry; the new value is visible next cycle.
- Reset mid-RUN aborts immediately. LUT contents are lost and must be reloaded.
- branch/sc_in are ignored outside RUN.

Optional Feature:
RELATIVE_BRANCH_EN
- Defined: LUT entries are signed two's-complement offsets. Taken branch next PC = PC + sign-extended LUT[target_sel], modulo 2^PC_W.
- Undefined: LUT entries are absolute addresses, as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef branch_t (enum BR_NONE=00, BR_SC1=01, BR_SC0=10, BR_ALWAYS=11), shared with the control decoder.
  - typedef fetch_state_t (IDLE, RUN, DONE).
  - Constants PC_W_DEF=10, INSTR_W_DEF=9, LUT_IDX_W=4.
- One sub-module, jump_lut: register file with one synchronous write port, one combinational read port, and async reset to 0.

Test Plan:
- Reset then start, prog_last=3, branch=00 throughout -> rom_addr 0,1,2,3; done=1 on the 5th cycle after start; cycle_cnt=4.
- Load LUT[5]=10'd40, run, at PC=2 drive branch=11, target_sel=5 -> next rom_addr=40.
- Conditional branches with LUT[1]=100:
  - branch=01, sc_in=0 -> PC+1.
  - branch=01, sc_in=1 -> 100.
  - branch=10, sc_in=0 -> 100.
- Same-cycle write/lookup: lut_wr_en with idx 5, data 7, and a taken branch on idx 5 holding 40 -> jump to 40; the next taken branch on idx 5 -> 7.
- Wrap and reset:
  - prog_last=1, PC forced through 1023 via a branch to LUT=1023 -> next 0, then done after address 1.
  - Assert Reset mid-RUN -> outputs return to reset values immediately.
- RELATIVE_BRANCH_EN build: LUT[2]=10'h3FE (-2), taken branch at PC=10 -> 8.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decoder types: branch encoding, fetch FSM states and default widths.
// Used by instr_fetch and jump_lut (RELATIVE_BRANCH_EN is handled in instr_fetch).
package fetch_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 9;
    localparam int LUT_IDX_W   = 4;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_SC1    = 2'b01,
        BR_SC0    = 2'b10,
        BR_ALWAYS = 2'b11
    } branch_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } fetch_state_t;

    function automatic logic branch_taken(input branch_t br, input logic sc);
        case (br)
            BR_SC1:    return sc;
            BR_SC0:    return ~sc;
            BR_ALWAYS: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jump_lut.sv
// Jump-target register file: one synchronous write port, one combinational
// read port, all entries cleared by asynchronous reset.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = LUT_IDX_W,
    parameter int DATA_W = PC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read returns the pre-write value when the same entry is written this cycle.
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/instr_fetch.sv
// Program counter / fetch unit: sequences IDLE -> RUN -> DONE, resolves branches
// through jump_lut. Define RELATIVE_BRANCH_EN to treat table entries as signed PC offsets.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int LUT_DEPTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [PC_W-1:0]      prog_last,
    output logic [PC_W-1:0]      rom_addr,
    input  logic [INSTR_W-1:0]   rom_data,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    input  logic [1:0]           branch,
    input  logic [LUT_IDX_W-1:0] target_sel,
    input  logic                 sc_in,
    input  logic                 lut_wr_en,
    input  logic [LUT_IDX_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic                 done,
    output logic [15:0]          cycle_cnt,
    output fetch_state_t         dbg_state_o
);

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     cnt_q;
    logic            done_q;
    logic            valid_q;

    logic [PC_W-1:0] lut_rd;
    logic [PC_W-1:0] target_d;
    logic [PC_W-1:0] pc_inc_d;
    logic [15:0]     cnt_d;
    logic            taken_d;

    jump_lut #(
        .DEPTH  (LUT_DEPTH),
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_jump_lut (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .wr_en_i   (lut_wr_en),
        .wr_idx_i  (lut_wr_idx),
        .wr_data_i (lut_wr_data),
        .rd_idx_i  (target_sel),
        .rd_data_o (lut_rd)
    );

    always_comb begin
        taken_d  = branch_taken(branch_t'(branch), sc_in);
        pc_inc_d = pc_q + PC_W'(1);
        cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`ifdef RELATIVE_BRANCH_EN
        // Same-width add is the sign-extended offset taken modulo 2^PC_W.
        target_d = pc_q + lut_rd;
`else
        target_d = lut_rd;
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (taken_d) begin
                        pc_q <= target_d;
                    end else if (pc_q == prog_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = valid_q ? rom_data : '0;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign cycle_cnt   = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed steps plus randomized traffic against an
// integer reference model; honours RELATIVE_BRANCH_EN like the design.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
`ifdef RELATIVE_BRANCH_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               Clk = 1'b0;
    logic               Reset;
    logic               start;
    logic [PC_W-1:0]    prog_last;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [1:0]         branch;
    logic [3:0]         target_sel;
    logic               sc_in;
    logic               lut_wr_en;
    logic [3:0]         lut_wr_idx;
    logic [PC_W-1:0]    lut_wr_data;
    logic               done;
    logic [15:0]        cycle_cnt;
    fetch_state_t       dbg_state;

    always #5 Clk = ~Clk;

    logic [INSTR_W-1:0] rom [1024];
    assign rom_data = rom[rom_addr];

    instr_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .prog_last   (prog_last),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .branch      (branch),
        .target_sel  (target_sel),
        .sc_in       (sc_in),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [INSTR_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;
    int m_lut [16];

    function automatic void model_reset();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_pc   = 0;
        m_cnt  = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endfunction

    function automatic void model_step();
        bit take;
        int off;
        if (!m_run) begin
            if (start) begin
                m_run  = 1'b1;
                m_done = 1'b0;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end else begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            take  = (branch == 2'd3) || (branch == 2'd1 && sc_in) || (branch == 2'd2 && !sc_in);
            if (take) begin
                off  = (m_lut[target_sel] >= 512) ? m_lut[target_sel] - 1024 : m_lut[target_sel];
                m_pc = REL ? (m_pc + off + 1024) % 1024 : m_lut[target_sel];
            end else if (m_pc == int'(prog_last)) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        start       = 1'b0;
        branch      = 2'd0;
        sc_in       = 1'b0;
        target_sel  = 4'd0;
        lut_wr_en   = 1'b0;
        lut_wr_idx  = 4'd0;
        lut_wr_data = '0;
    endtask

    // One clock: advance the model on the current inputs, then compare all outputs.
    task automatic cycle();
        if (Reset) model_reset();
        else       model_step();
        exp_q.push_back(m_run ? rom[m_pc] : '0);
        @(posedge Clk);
        #1;
        chk("rom_addr", 32'(rom_addr), m_pc);
        chk("instr", 32'(instr), 32'(exp_q.pop_front()));
        chk("instr_valid", 32'(instr_valid), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("cycle_cnt", 32'(cycle_cnt), m_cnt);
    endtask

    task automatic lut_write(input int idx, input int data);
        lut_wr_en   = 1'b1;
        lut_wr_idx  = 4'(idx);
        lut_wr_data = PC_W'(data);
        cycle();
        lut_wr_en   = 1'b0;
    endtask

    task automatic br(input int b, input bit sc, input int sel);
        branch     = 2'(b);
        sc_in      = sc;
        target_sel = 4'(sel);
        cycle();
        branch     = 2'd0;
        sc_in      = 1'b0;
    endtask

    task automatic start_prog(input int last);
        prog_last = PC_W'(last);
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int p;
        for (int i = 0; i < 1024; i++) rom[i] = INSTR_W'($urandom_range(1, 511));
        idle_inputs();
        prog_last = PC_W'(3);
        Reset = 1'b1;
        model_reset();
        cycle();
        cycle();
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        Reset = 1'b0;
        cycle();
        chk("idle_stays", 32'(instr_valid), 0);

        // Straight-line program 0..3, done after the 5th edge from start.
        start_prog(3);
        chk("t1_addr0", 32'(rom_addr), 0);
        chk("t1_instr0", 32'(instr), 32'(rom[0]));
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("t1_addr", 32'(rom_addr), i);
        end
        cycle();
        chk("t1_done", 32'(done), 1);
        chk("t1_cnt", 32'(cycle_cnt), 4);
        chk("t1_hold_addr", 32'(rom_addr), 3);
        chk("t1_instr_off", 32'(instr), 0);
        br(3, 1'b0, 0);
        chk("done_ignores_br", 32'(rom_addr), 3);

        lut_write(5, 40);
        lut_write(1, 100);
        lut_write(2, 10'h3FE);
        lut_write(9, 10'h3FF);

        // Unconditional branch at PC=2; start during RUN is ignored.
        start_prog(500);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_in_run", 32'(rom_addr), 1);
        cycle();
        br(3, 1'b0, 5);
        p = REL ? 42 : 40;
        chk("br_always", 32'(rom_addr), p);

        br(1, 1'b0, 1);
        p = p + 1;
        chk("br_sc1_nt", 32'(rom_addr), p);
        br(1, 1'b1, 1);
        p = REL ? p + 100 : 100;
        chk("br_sc1_t", 32'(rom_addr), p);
        br(2, 1'b0, 1);
        p = REL ? p + 100 : 100;
        chk("br_sc0_t", 32'(rom_addr), p);
        br(2, 1'b1, 1);
        p = p + 1;
        chk("br_sc0_nt", 32'(rom_addr), p);
        prog_last = PC_W'(p);
        cycle();
        chk("end_prog2", 32'(done), 1);

        // Entry 2 holds 10'h3FE (-2 as an offset).
        start_prog(500);
        for (int i = 0; i < 10; i++) cycle();
        chk("at_pc10", 32'(rom_addr), 10);
        br(3, 1'b0, 2);
        p = REL ? 8 : 1022;
        chk("br_neg", 32'(rom_addr), p);

        // Write and lookup of entry 5 in the same cycle uses the old value.
        lut_wr_en   = 1'b1;
        lut_wr_idx  = 4'd5;
        lut_wr_data = PC_W'(7);
        br(3, 1'b0, 5);
        lut_wr_en   = 1'b0;
        p = REL ? (p + 40) % 1024 : 40;
        chk("wr_same_old", 32'(rom_addr), p);
        br(3, 1'b0, 5);
        p = REL ? (p + 7) % 1024 : 7;
        chk("wr_same_new", 32'(rom_addr), p);
        prog_last = PC_W'(p);
        cycle();
        chk("end_prog3", 32'(done), 1);

        // PC wrap 1023 -> 0 (entry 9 is 1023 absolute, or -1 relative from 0).
        start_prog(1);
        br(3, 1'b0, 9);
        chk("wrap_1023", 32'(rom_addr), 1023);
        cycle();
        chk("wrap_0", 32'(rom_addr), 0);
        cycle();
        chk("wrap_1", 32'(rom_addr), 1);
        cycle();
        chk("wrap_done", 32'(done), 1);
        chk("wrap_hold", 32'(rom_addr), 1);

        // Randomized traffic.
        prog_last = PC_W'($urandom_range(20, 60));
        for (int i = 0; i < 800; i++) begin
            int r;
            if (!m_run) begin
                prog_last = PC_W'($urandom_range(20, 60));
                start     = ($urandom_range(0, 3) == 0);
            end else begin
                start     = ($urandom_range(0, 7) == 0);
            end
            r           = $urandom_range(0, 11);
            branch      = (r < 8) ? 2'd0 : 2'(r - 8);
            sc_in       = 1'($urandom_range(0, 1));
            target_sel  = 4'($urandom_range(0, 15));
            lut_wr_en   = ($urandom_range(0, 3) == 0);
            lut_wr_idx  = 4'($urandom_range(0, 15));
            lut_wr_data = PC_W'($urandom_range(0, 70));
            cycle();
        end
        idle_inputs();
        chk("rand_cnt_bound", 32'(cycle_cnt <= 16'd800), 1);

        // Asynchronous reset in the middle of RUN.
        if (m_run) begin
            prog_last = PC_W'(500);
            cycle();
        end else begin
            start_prog(500);
        end
        for (int i = 0; i < 4; i++) cycle();
        #2 Reset = 1'b1;
        #1;
        chk("arst_addr", 32'(rom_addr), 0);
        chk("arst_instr", 32'(instr), 0);
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_cnt", 32'(cycle_cnt), 0);
        model_reset();
        cycle();
        Reset = 1'b0;

        // Table was cleared: entry 5 now reads 0.
        start_prog(500);
        cycle();
        br(3, 1'b0, 5);
        p = REL ? 1 : 0;
        chk("lut_cleared", 32'(rom_addr), p);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
